sm_ingress_arbiter: RTL and testbench
=====================================

Name: sm_ingress_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one string-matcher ingress (in_pkt plus in_meta of string_matcher_wrapper) between N_PORTS requesters.
- Each requester supplies one metadata beat followed by one packet (sop..eop).
- Forwards the metadata beat first, then locks the grant for the whole packet, so metadata/packet pairs reach the matcher atomically and in order.
- Sits in the matcher clock domain, between the upstream client shims and the matcher.

Parameters:
- N_PORTS, 4, number of requesters (2..8).
- DATA_W, 512, packet flit width.
- EMPTY_W, 6, empty-byte field width.
- META_W, 128, metadata width; set to $bits(metadata_t) at instantiation.

Ports:
- clk  in  1  matcher clock.
- rst  in  1  synchronous reset, active-high.
- cfg_port_en  in  N_PORTS  per-port arbitration enable.
- in_meta_valid  in  N_PORTS  per-port metadata valid.
- in_meta_data  in  N_PORTS*META_W  per-port metadata, port i at slice i.
- in_meta_ready  out  N_PORTS  per-port metadata ready.
- in_pkt_valid, in_pkt_sop, in_pkt_eop  in  N_PORTS each  per-port flit controls.
- in_pkt_data  in  N_PORTS*DATA_W  per-port flit data.
- in_pkt_empty  in  N_PORTS*EMPTY_W  per-port empty field.
- in_pkt_ready  out  N_PORTS  per-port flit ready.
- out_meta_valid  out  1  metadata to matcher.
- out_meta_data  out  META_W  metadata to matcher.
- out_meta_ready  in  1  matcher metadata ready.
- out_pkt_valid, out_pkt_sop, out_pkt_eop  out  1 each  flit controls to matcher.
- out_pkt_data  out  DATA_W  flit data to matcher.
- out_pkt_empty  out  EMPTY_W  flit empty field to matcher.
- out_pkt_ready  in  1  matcher flit ready.
- out_pkt_almost_full  in  1  matcher backpressure hint.
- grant_id  out  clog2(N_PORTS)  currently granted port.
- grant_active  out  1  high in META or PKT.
- proto_err  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - State IDLE; rr_ptr=0; grant_id=0; proto_err=0.
  - All ready and valid outputs 0; out_*_data/empty/sop/eop 0 while out_*_valid=0.
- State IDLE:
  - req = in_meta_valid & cfg_port_en.
  - Transition only when req != 0 and out_pkt_almost_full=0.
  - Winner = first set bit of req searching from rr_ptr upward with wrap.
  - Register grant_id=winner; go to META next cycle (1-cycle arbitration latency).
  - All readies are 0 in IDLE.
- State META:
  - out_meta_valid = in_meta_valid[grant_id]; out_meta_data = slice grant_id.
  - in_meta_ready[grant_id] = out_meta_ready; all other meta readies 0.
  - On handshake (valid & ready) go to PKT.
  - No pkt flits pass in META.
- State PKT:
  - Combinational pass-through of the granted port: out_pkt_* = slice grant_id.
  - in_pkt_ready[grant_id] = out_pkt_ready; other ports' ready = 0.
  - A transfer occurs only when valid & ready.
  - On accepted flit with eop=1: go to IDLE; rr_ptr = grant_id+1, wrapping to 0 at N_PORTS.
- Single-flit packet (sop=eop=1): META to PKT to IDLE; minimum 3 cycles per packet.
- Protocol errors, each sets proto_err (sticky until rst):
  - First accepted flit in PKT has sop=0.
  - A later flit has sop=1.
  - The flit is still forwarded unchanged.
- cfg_port_en:
  - Sampled only in IDLE.
  - Clearing the bit of the granted port mid-META/PKT does not abort; the grant holds until eop.
- out_pkt_almost_full is ignored after the grant is issued.
- Reset mid-packet: immediate return to IDLE and reset values. Upstream is reset in the same domain.
- Metadata not accompanied by a packet stalls the arbiter in PKT; this is upstream's responsibility.

Optional Feature:
- Macro: SM_ARB_STATS_EN.
- When defined, adds output stats_pkt_cnt [N_PORTS*32].
  - Per-port count of accepted eop flits.
  - Reset 0, wraps at 2^32.
  - Adds output stats_stall_cnt [32], counting cycles where req!=0 and out_pkt_almost_full=1 in IDLE.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single port 0, 3-flit packet, ready=1 throughout:
  - Grant at cycle 1, meta handshake cycle 1, flits out cycles 2-4.
  - grant_active drops cycle 5; rr_ptr=1.
- All 4 ports requesting continuously, 1-flit packets:
  - grant_id sequence 0,1,2,3,0.
  - Each meta precedes its own flit; no interleaving.
- Port 2 mid-packet with out_pkt_ready toggling 1,0,1,0:
  - Flits held stable while ready=0.
  - Port 1 requests during this window and gets in_pkt_ready=0 until port 2's eop.
- cfg_port_en=4'b1010 with all ports requesting:
  - Only ports 1 and 3 granted, alternating.
  - Clearing bit 3 during its packet still completes that packet.
- out_pkt_almost_full=1 in IDLE with req=4'b0001:
  - No grant issued.
  - Deassert af: grant follows in the next cycle.
- Port 0 first flit sop=0:
  - proto_err=1, flit forwarded.
  - rst clears proto_err; with SM_ARB_STATS_EN, stats_pkt_cnt[0] increments once per eop.

Source files
------------

// File: rtl/sm_ingress_arbiter.sv
// sm_ingress_arbiter: packet-granular round-robin arbiter that shares one
// string-matcher ingress (metadata beat + packet) between N_PORTS requesters.
// A granted port first forwards one metadata beat, then owns the packet path
// until its eop flit is accepted, so meta/packet pairs stay atomic and ordered.
//
// Ports:
//   clk, rst                 matcher clock, synchronous active-high reset
//   cfg_port_en              per-port arbitration enable (sampled in IDLE)
//   in_meta_*                per-port metadata beat (valid/data/ready)
//   in_pkt_*                 per-port flit stream (valid/sop/eop/data/empty/ready)
//   out_meta_*               metadata towards the matcher
//   out_pkt_*                flit stream towards the matcher
//   out_pkt_almost_full      matcher backpressure hint, blocks new grants only
//   grant_id, grant_active   current owner and busy indication
//   proto_err                sticky sop-framing error
//
// Optional build macro SM_ARB_STATS_EN adds:
//   stats_pkt_cnt            per-port count of accepted eop flits (32 b each)
//   stats_stall_cnt          IDLE cycles with a request held off by almost_full
module sm_ingress_arbiter #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned EMPTY_W = 6,
  parameter int unsigned META_W  = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORTS-1:0]           cfg_port_en,
  input  logic [N_PORTS-1:0]           in_meta_valid,
  input  logic [N_PORTS*META_W-1:0]    in_meta_data,
  output logic [N_PORTS-1:0]           in_meta_ready,
  input  logic [N_PORTS-1:0]           in_pkt_valid,
  input  logic [N_PORTS-1:0]           in_pkt_sop,
  input  logic [N_PORTS-1:0]           in_pkt_eop,
  input  logic [N_PORTS*DATA_W-1:0]    in_pkt_data,
  input  logic [N_PORTS*EMPTY_W-1:0]   in_pkt_empty,
  output logic [N_PORTS-1:0]           in_pkt_ready,
  output logic                         out_meta_valid,
  output logic [META_W-1:0]            out_meta_data,
  input  logic                         out_meta_ready,
  output logic                         out_pkt_valid,
  output logic                         out_pkt_sop,
  output logic                         out_pkt_eop,
  output logic [DATA_W-1:0]            out_pkt_data,
  output logic [EMPTY_W-1:0]           out_pkt_empty,
  input  logic                         out_pkt_ready,
  input  logic                         out_pkt_almost_full,
  output logic [$clog2(N_PORTS)-1:0]   grant_id,
  output logic                         grant_active,
  output logic                         proto_err
`ifdef SM_ARB_STATS_EN
  ,
  output logic [N_PORTS*32-1:0]        stats_pkt_cnt,
  output logic [31:0]                  stats_stall_cnt
`endif
);

  localparam int unsigned ID_W  = $clog2(N_PORTS);
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_META = 2'd1,
    S_PKT  = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_next;
  logic [ID_W-1:0]   winner;
  logic              first_flit;
  logic [N_PORTS-1:0] req;
  logic              meta_hs;
  logic              pkt_hs;
  logic              cur_sop;
  logic              cur_eop;

  // Per-port views of the flattened payload buses.
  logic [META_W-1:0]  meta_arr  [N_PORTS];
  logic [DATA_W-1:0]  data_arr  [N_PORTS];
  logic [EMPTY_W-1:0] empty_arr [N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign meta_arr[i]  = in_meta_data[i*META_W +: META_W];
    assign data_arr[i]  = in_pkt_data[i*DATA_W +: DATA_W];
    assign empty_arr[i] = in_pkt_empty[i*EMPTY_W +: EMPTY_W];
  end

  assign req          = in_meta_valid & cfg_port_en;
  assign grant_active = (state != S_IDLE);
  assign cur_sop      = in_pkt_sop[grant_id];
  assign cur_eop      = in_pkt_eop[grant_id];
  assign meta_hs      = (state == S_META) && in_meta_valid[grant_id] && out_meta_ready;
  assign pkt_hs       = (state == S_PKT) && in_pkt_valid[grant_id] && out_pkt_ready;
  assign rr_next      = (grant_id == ID_W'(N_PORTS - 1)) ? '0 : grant_id + 1'b1;

  // Round-robin search: first requesting port at or above rr_ptr, wrapping.
  always_comb begin : arb_search
    int unsigned cand;
    logic        found;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      cand = (32'(rr_ptr) + k) % N_PORTS;
      if (!found && req[ID_W'(cand)]) begin
        winner = ID_W'(cand);
        found  = 1'b1;
      end
    end
  end

  // Steer the granted port onto the matcher; payload is zero while invalid.
  always_comb begin : steer
    out_meta_valid = 1'b0;
    out_meta_data  = '0;
    in_meta_ready  = '0;
    out_pkt_valid  = 1'b0;
    out_pkt_sop    = 1'b0;
    out_pkt_eop    = 1'b0;
    out_pkt_data   = '0;
    out_pkt_empty  = '0;
    in_pkt_ready   = '0;
    case (state)
      S_META: begin
        out_meta_valid          = in_meta_valid[grant_id];
        in_meta_ready[grant_id] = out_meta_ready;
        if (out_meta_valid) begin
          out_meta_data = meta_arr[grant_id];
        end
      end
      S_PKT: begin
        out_pkt_valid          = in_pkt_valid[grant_id];
        in_pkt_ready[grant_id] = out_pkt_ready;
        if (out_pkt_valid) begin
          out_pkt_sop   = cur_sop;
          out_pkt_eop   = cur_eop;
          out_pkt_data  = data_arr[grant_id];
          out_pkt_empty = empty_arr[grant_id];
        end
      end
      default: ;
    endcase
  end

  // Grant FSM: arbitrate in IDLE, one meta beat, then hold until eop.
  always_ff @(posedge clk) begin : fsm
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      proto_err  <= 1'b0;
      first_flit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((|req) && !out_pkt_almost_full) begin
            grant_id <= winner;
            state    <= S_META;
          end
        end
        S_META: begin
          if (meta_hs) begin
            state      <= S_PKT;
            first_flit <= 1'b1;
          end
        end
        S_PKT: begin
          if (pkt_hs) begin
            first_flit <= 1'b0;
            // sop must be set on the first flit and only there
            if (first_flit != cur_sop) begin
              proto_err <= 1'b1;
            end
            if (cur_eop) begin
              state  <= S_IDLE;
              rr_ptr <= rr_next;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SM_ARB_STATS_EN
  logic [CNT_W-1:0] pkt_cnt [N_PORTS];
  logic [CNT_W-1:0] stall_cnt;

  // Free-running wrap-around statistics counters.
  always_ff @(posedge clk) begin : stats
    if (rst) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        pkt_cnt[i] <= '0;
      end
      stall_cnt <= '0;
    end else begin
      if (pkt_hs && cur_eop) begin
        pkt_cnt[grant_id] <= pkt_cnt[grant_id] + CNT_W'(1);
      end
      if ((state == S_IDLE) && (|req) && out_pkt_almost_full) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_stats
    assign stats_pkt_cnt[i*CNT_W +: CNT_W] = pkt_cnt[i];
  end
  assign stats_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_sm_ingress_arbiter.sv
// Self-checking bench for sm_ingress_arbiter (4 ports, narrow buses).
module tb_sm_ingress_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int EW = 6;
  localparam int MW = 16;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     en, mv, mr, fv, fsop, feop, fr;
  logic [NP*MW-1:0]  md;
  logic [NP*DW-1:0]  fd;
  logic [NP*EW-1:0]  fe;
  logic              omv, omr, opv, ops, opeop, opr, af;
  logic [MW-1:0]     omd;
  logic [DW-1:0]     opd;
  logic [EW-1:0]     opemp;
  logic [1:0]        gid;
  logic              ga, perr;
`ifdef SM_ARB_STATS_EN
  logic [NP*32-1:0]  st_pkt;
  logic [31:0]       st_stall;
`endif

  int n_chk = 0;
  int n_fail = 0;

  sm_ingress_arbiter #(.N_PORTS(NP), .DATA_W(DW), .EMPTY_W(EW), .META_W(MW)) dut (
    .clk(clk), .rst(rst), .cfg_port_en(en),
    .in_meta_valid(mv), .in_meta_data(md), .in_meta_ready(mr),
    .in_pkt_valid(fv), .in_pkt_sop(fsop), .in_pkt_eop(feop),
    .in_pkt_data(fd), .in_pkt_empty(fe), .in_pkt_ready(fr),
    .out_meta_valid(omv), .out_meta_data(omd), .out_meta_ready(omr),
    .out_pkt_valid(opv), .out_pkt_sop(ops), .out_pkt_eop(opeop),
    .out_pkt_data(opd), .out_pkt_empty(opemp), .out_pkt_ready(opr),
    .out_pkt_almost_full(af), .grant_id(gid), .grant_active(ga), .proto_err(perr)
`ifdef SM_ARB_STATS_EN
    , .stats_pkt_cnt(st_pkt), .stats_stall_cnt(st_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic          sop;
    logic          eop;
  } flit_t;

  typedef struct {
    logic [3:0] en;
    logic [3:0] req;
    logic       af;
    logic       exp_ga;
    logic [1:0] exp_gid;
  } arb_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    en = '0; mv = '0; md = '0; fv = '0; fsop = '0; feop = '0; fd = '0; fe = '0;
    omr = 1'b0; opr = 1'b0; af = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic set_meta(input int p, input logic v, input logic [MW-1:0] d);
    mv[p] = v;
    md[p*MW +: MW] = d;
  endtask

  task automatic set_flit(input int p, input logic v, input logic [DW-1:0] d,
                          input logic s, input logic e, input logic [EW-1:0] emp);
    fv[p] = v;
    fd[p*DW +: DW] = d;
    fsop[p] = s;
    feop[p] = e;
    fe[p*EW +: EW] = emp;
  endtask

  // All ports stream 1-flit packets; record the grant order at each meta handshake.
  task automatic run_rr(input string tag, input logic [3:0] en0, input int clr_at,
                        input int exp_seq [6]);
    int got;
    int cyc;
    int last_port;
    int pending;
    do_reset();
    en = en0; omr = 1'b1; opr = 1'b1;
    for (int p = 0; p < NP; p++) begin
      set_meta(p, 1'b1, 16'hA000 + 16'(p));
      set_flit(p, 1'b1, 32'hD000_0000 + 32'(p), 1'b1, 1'b1, '0);
    end
    got = 0; cyc = 0; last_port = 0; pending = 0;
    while (got < 6 && cyc < 100) begin
      settle();
      if (omv && omr) begin
        chk({tag, "_gid"}, 64'(gid), 64'(exp_seq[got]));
        chk({tag, "_meta"}, 64'(omd), 64'(16'hA000 + 16'(exp_seq[got])));
        chk({tag, "_no_interleave"}, 64'(pending), 64'd0);
        pending = 1;
        last_port = exp_seq[got];
        if (got == clr_at) en = en & ~(4'b0001 << exp_seq[got]);
        got++;
      end
      if (opv && opr) begin
        chk({tag, "_pkt_port"}, 64'(opd), 64'(32'hD000_0000 + 32'(last_port)));
        pending = 0;
      end
      next_cycle();
      cyc++;
    end
    chk({tag, "_done"}, 64'(got), 64'd6);
  endtask

  // Random traffic against a transaction-level reference model.
  task automatic run_random;
    flit_t       fq [NP][$];
    logic [MW-1:0] mq [NP][$];
    flit_t       f;
    int          m_owner, m_ptr, m_cnt [NP], m_stall, remaining, cyc, len;
    logic        m_inmeta, m_err, m_first;
    logic [1:0]  m_gid;
    logic [3:0]  req, e_mr, e_fr;
    logic        e_omv, e_opv, e_ops, e_eop;
    logic [MW-1:0] e_omd;
    logic [DW-1:0] e_opd;
    logic [EW-1:0] e_emp;

    do_reset();
    for (int p = 0; p < NP; p++) begin
      m_cnt[p] = 0;
      for (int k = 0; k < 6; k++) begin
        mq[p].push_back(16'($urandom));
        len = int'($urandom_range(1, 4));
        for (int j = 0; j < len; j++) begin
          f.data  = $urandom;
          f.empty = 6'($urandom);
          f.sop   = (j == 0);
          f.eop   = (j == len - 1);
          if ($urandom_range(0, 19) == 0) f.sop = ~f.sop;
          fq[p].push_back(f);
        end
      end
    end
    m_owner = -1; m_ptr = 0; m_stall = 0; m_inmeta = 0; m_err = 0; m_first = 0; m_gid = 0;
    remaining = 1; cyc = 0;
    while (remaining != 0 && cyc < 4000) begin
      for (int p = 0; p < NP; p++) begin
        set_meta(p, (mq[p].size() > 0) && ($urandom_range(0, 3) != 0),
                 (mq[p].size() > 0) ? mq[p][0] : 16'($urandom));
        if (fq[p].size() > 0) begin
          f = fq[p][0];
          set_flit(p, $urandom_range(0, 3) != 0, f.data, f.sop, f.eop, f.empty);
        end else begin
          set_flit(p, 1'b0, $urandom, 1'($urandom), 1'($urandom), 6'($urandom));
        end
      end
      en  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      omr = ($urandom_range(0, 3) != 0);
      opr = ($urandom_range(0, 3) != 0);
      af  = ($urandom_range(0, 4) == 0);
      settle();

      e_omv = 0; e_omd = '0; e_mr = '0; e_opv = 0; e_opd = '0; e_ops = 0; e_eop = 0;
      e_emp = '0; e_fr = '0;
      if (m_owner >= 0 && m_inmeta) begin
        e_omv = mv[m_owner];
        if (e_omv) e_omd = mq[m_owner][0];
        e_mr[m_owner] = omr;
      end else if (m_owner >= 0) begin
        e_opv = fv[m_owner];
        if (e_opv) begin
          f = fq[m_owner][0];
          e_opd = f.data; e_ops = f.sop; e_eop = f.eop; e_emp = f.empty;
        end
        e_fr[m_owner] = opr;
      end
      chk("rnd_omv", 64'(omv), 64'(e_omv));
      chk("rnd_omd", 64'(omd), 64'(e_omd));
      chk("rnd_mready", 64'(mr), 64'(e_mr));
      chk("rnd_opv", 64'(opv), 64'(e_opv));
      chk("rnd_opd", 64'(opd), 64'(e_opd));
      chk("rnd_sop", 64'(ops), 64'(e_ops));
      chk("rnd_eop", 64'(opeop), 64'(e_eop));
      chk("rnd_empty", 64'(opemp), 64'(e_emp));
      chk("rnd_pready", 64'(fr), 64'(e_fr));
      chk("rnd_active", 64'(ga), 64'(m_owner >= 0));
      chk("rnd_gid", 64'(gid), 64'(m_gid));
      chk("rnd_err", 64'(perr), 64'(m_err));

      if (m_owner < 0) begin
        req = mv & en;
        if (req != 0 && af) m_stall++;
        if (req != 0 && !af) begin
          for (int k = 0; k < NP; k++) begin
            if (m_owner < 0 && req[(m_ptr + k) % NP]) m_owner = (m_ptr + k) % NP;
          end
          m_gid = 2'(m_owner);
          m_inmeta = 1;
        end
      end else if (m_inmeta) begin
        if (mv[m_owner] && omr) begin
          void'(mq[m_owner].pop_front());
          m_inmeta = 0;
          m_first = 1;
        end
      end else if (fv[m_owner] && opr) begin
        f = fq[m_owner].pop_front();
        if ((m_first && !f.sop) || (!m_first && f.sop)) m_err = 1;
        m_first = 0;
        if (f.eop) begin
          m_cnt[m_owner]++;
          m_ptr = (m_owner + 1) % NP;
          m_owner = -1;
        end
      end
      remaining = 0;
      for (int p = 0; p < NP; p++) remaining += mq[p].size() + fq[p].size();
      if (m_owner >= 0) remaining++;
      next_cycle();
      cyc++;
    end
    chk("rnd_drain", 64'(remaining), 64'd0);
`ifdef SM_ARB_STATS_EN
    for (int p = 0; p < NP; p++) chk("rnd_stats_pkt", 64'(st_pkt[p*32 +: 32]), 64'(m_cnt[p]));
    chk("rnd_stats_stall", 64'(st_stall), 64'(m_stall));
`endif
  endtask

  initial begin : main
    arb_vec_t vt [8];
    int       s_all [6];
    int       s_odd [6];
    int       pat_opr [5];
    int       pat_fi [5];

    vt[0] = '{4'hF, 4'b0001, 1'b0, 1'b1, 2'd0};
    vt[1] = '{4'hF, 4'b0100, 1'b0, 1'b1, 2'd2};
    vt[2] = '{4'hF, 4'b1100, 1'b0, 1'b1, 2'd2};
    vt[3] = '{4'b1010, 4'b1111, 1'b0, 1'b1, 2'd1};
    vt[4] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0};
    vt[5] = '{4'hF, 4'b0001, 1'b1, 1'b0, 2'd0};
    vt[6] = '{4'b1000, 4'b1001, 1'b0, 1'b1, 2'd3};
    vt[7] = '{4'hF, 4'b0000, 1'b0, 1'b0, 2'd0};
    s_all   = '{0, 1, 2, 3, 0, 1};
    s_odd   = '{1, 3, 1, 3, 1, 1};
    pat_opr = '{1, 0, 1, 0, 1};
    pat_fi  = '{0, 1, 1, 2, 2};
    clk = 1'b0;
    rst = 1'b1;
    clear_inputs();

    // Reset state
    do_reset();
    settle();
    chk("rst_active", 64'(ga), 64'd0);
    chk("rst_gid", 64'(gid), 64'd0);
    chk("rst_err", 64'(perr), 64'd0);
    chk("rst_mready", 64'(mr), 64'd0);
    chk("rst_pready", 64'(fr), 64'd0);
    chk("rst_omv", 64'(omv), 64'd0);
    chk("rst_opv", 64'(opv), 64'd0);

    // Single-shot arbitration decisions from reset (rr_ptr = 0)
    for (int i = 0; i < 8; i++) begin
      do_reset();
      en = vt[i].en; mv = vt[i].req; af = vt[i].af; omr = 1'b0;
      md = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      settle();
      chk("tbl_idle_mready", 64'(mr), 64'd0);
      next_cycle();
      settle();
      chk("tbl_active", 64'(ga), 64'(vt[i].exp_ga));
      chk("tbl_gid", 64'(gid), 64'(vt[i].exp_gid));
      if (vt[i].exp_ga) chk("tbl_meta", 64'(omd), 64'(16'hA000 + 16'(vt[i].exp_gid)));
    end

    // Port 0, 3-flit packet, ready held high: grant c1, flits c2..c4, idle c5
    do_reset();
    en = 4'hF; omr = 1'b1; opr = 1'b1;
    set_meta(0, 1'b1, 16'hA0A0);
    set_flit(0, 1'b1, 32'h1111_0000, 1'b1, 1'b0, 6'd0);
    settle();
    chk("s1_c0_active", 64'(ga), 64'd0);
    chk("s1_c0_omv", 64'(omv), 64'd0);
    next_cycle();
    settle();
    chk("s1_c1_active", 64'(ga), 64'd1);
    chk("s1_c1_gid", 64'(gid), 64'd0);
    chk("s1_c1_omv", 64'(omv), 64'd1);
    chk("s1_c1_omd", 64'(omd), 64'hA0A0);
    chk("s1_c1_mready", 64'(mr), 64'b0001);
    chk("s1_c1_opv", 64'(opv), 64'd0);
    chk("s1_c1_pready", 64'(fr), 64'd0);
    next_cycle();
    set_meta(0, 1'b0, '0);
    settle();
    chk("s1_c2_opv", 64'(opv), 64'd1);
    chk("s1_c2_opd", 64'(opd), 64'h1111_0000);
    chk("s1_c2_sop", 64'(ops), 64'd1);
    chk("s1_c2_pready", 64'(fr), 64'b0001);
    chk("s1_c2_omv", 64'(omv), 64'd0);
    next_cycle();
    set_flit(0, 1'b1, 32'h1111_0001, 1'b0, 1'b0, 6'd0);
    settle();
    chk("s1_c3_opd", 64'(opd), 64'h1111_0001);
    chk("s1_c3_sop", 64'(ops), 64'd0);
    next_cycle();
    set_flit(0, 1'b1, 32'h1111_0002, 1'b0, 1'b1, 6'd5);
    settle();
    chk("s1_c4_opd", 64'(opd), 64'h1111_0002);
    chk("s1_c4_eop", 64'(opeop), 64'd1);
    chk("s1_c4_empty", 64'(opemp), 64'd5);
    next_cycle();
    set_flit(0, 1'b0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("s1_c5_active", 64'(ga), 64'd0);
    chk("s1_c5_opv", 64'(opv), 64'd0);
`ifdef SM_ARB_STATS_EN
    chk("s1_stats_pkt0", 64'(st_pkt[31:0]), 64'd1);
`endif
    mv = 4'hF;
    next_cycle();
    settle();
    chk("s1_rr_next_gid", 64'(gid), 64'd1);

    // Continuous 1-flit requests: strict rotation, then only odd ports enabled
    run_rr("rr_all", 4'hF, -1, s_all);
    run_rr("rr_odd", 4'b1010, 3, s_odd);

    // Port 2 packet under toggling ready while port 1 waits
    do_reset();
    en = 4'hF; omr = 1'b1;
    set_meta(2, 1'b1, 16'hC2C2);
    next_cycle();
    settle();
    chk("s3_gid", 64'(gid), 64'd2);
    next_cycle();
    set_meta(2, 1'b0, '0);
    set_meta(1, 1'b1, 16'hB1B1);
    set_flit(1, 1'b1, 32'hBBBB_0000, 1'b1, 1'b1, '0);
    for (int k = 0; k < 5; k++) begin
      set_flit(2, 1'b1, 32'hCCCC_0000 + 32'(pat_fi[k]), pat_fi[k] == 0, pat_fi[k] == 2, '0);
      opr = 1'(pat_opr[k]);
      settle();
      chk("s3_opd", 64'(opd), 64'(32'hCCCC_0000 + 32'(pat_fi[k])));
      chk("s3_pready", 64'(fr), (pat_opr[k] != 0) ? 64'b0100 : 64'd0);
      chk("s3_mready", 64'(mr), 64'd0);
      next_cycle();
    end
    set_flit(2, 1'b0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("s3_idle", 64'(ga), 64'd0);
    next_cycle();
    settle();
    chk("s3_next_active", 64'(ga), 64'd1);
    chk("s3_next_gid", 64'(gid), 64'd1);

    // almost_full holds off the grant; grant follows the cycle after release
    do_reset();
    en = 4'hF;
    set_meta(0, 1'b1, 16'h0F0F);
    af = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("s5_af_active", 64'(ga), 64'd0);
      chk("s5_af_mready", 64'(mr), 64'd0);
      next_cycle();
    end
    af = 1'b0;
    settle();
    chk("s5_release_active", 64'(ga), 64'd0);
    next_cycle();
    settle();
    chk("s5_grant_active", 64'(ga), 64'd1);
    chk("s5_grant_gid", 64'(gid), 64'd0);
`ifdef SM_ARB_STATS_EN
    chk("s5_stall_cnt", 64'(st_stall), 64'd3);
`endif

    // First flit without sop: forwarded, proto_err sticky until reset
    do_reset();
    en = 4'hF; omr = 1'b1; opr = 1'b1;
    set_meta(0, 1'b1, 16'hE0E0);
    set_flit(0, 1'b1, 32'hEEEE_0001, 1'b0, 1'b1, 6'd3);
    next_cycle();
    settle();
    chk("s6_meta_err", 64'(perr), 64'd0);
    next_cycle();
    set_meta(0, 1'b0, '0);
    settle();
    chk("s6_opv", 64'(opv), 64'd1);
    chk("s6_sop", 64'(ops), 64'd0);
    chk("s6_opd", 64'(opd), 64'hEEEE_0001);
    chk("s6_pre_err", 64'(perr), 64'd0);
    next_cycle();
    set_flit(0, 1'b0, '0, 1'b0, 1'b0, '0);
    settle();
    chk("s6_err_set", 64'(perr), 64'd1);
    chk("s6_idle", 64'(ga), 64'd0);
    next_cycle();
    settle();
    chk("s6_err_sticky", 64'(perr), 64'd1);
`ifdef SM_ARB_STATS_EN
    chk("s6_stats_pkt0", 64'(st_pkt[31:0]), 64'd1);
`endif
    do_reset();
    settle();
    chk("s6_err_cleared", 64'(perr), 64'd0);
`ifdef SM_ARB_STATS_EN
    chk("s6_stats_cleared", 64'(st_pkt[31:0]), 64'd0);
`endif

    run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
